// File: rtl/serial_and_or_reducer.sv
// Purpose: serial AND/OR reduction of N-bit frames (z = XOR parity when REDUCE_XOR_EN is defined).
// Latency: result valid 1 cycle after the Nth bit is accepted.
// Backpressure: the result is held and input is refused until out_ready; clear aborts the frame or result.
module serial_and_or_reducer #(
    parameter int N = 3,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_bit,
    output logic          in_ready,
    input  logic          clear,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          x,
    output logic          y,
`ifdef REDUCE_XOR_EN
    output logic          z,
`endif
    output logic [CW-1:0] count
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Count value at which the next accepted bit completes the frame.
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    state_t          state_q, state_d;
    logic            acc_and_q, acc_and_d;
    logic            acc_or_q, acc_or_d;
    logic [CW-1:0]   count_q, count_d;
    logic            accept;
`ifdef REDUCE_XOR_EN
    logic            acc_xor_q, acc_xor_d;
`endif

    // A bit is consumed only while accumulating, and never in a clear cycle.
    assign accept = (state_q == ACCUM) && in_valid && !clear;

    // Next-state and accumulator update; clear overrides acceptance and release.
    always_comb begin
        state_d   = state_q;
        acc_and_d = acc_and_q;
        acc_or_d  = acc_or_q;
        count_d   = count_q;
`ifdef REDUCE_XOR_EN
        acc_xor_d = acc_xor_q;
`endif
        if (clear) begin
            state_d   = ACCUM;
            acc_and_d = 1'b1;
            acc_or_d  = 1'b0;
            count_d   = '0;
`ifdef REDUCE_XOR_EN
            acc_xor_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_and_d = acc_and_q & in_bit;
                        acc_or_d  = acc_or_q | in_bit;
                        count_d   = count_q + 1'b1;
`ifdef REDUCE_XOR_EN
                        acc_xor_d = acc_xor_q ^ in_bit;
`endif
                        if (count_q == LAST_IDX) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Release re-arms the accumulators; the next bit comes a cycle later.
                    if (out_ready) begin
                        state_d   = ACCUM;
                        acc_and_d = 1'b1;
                        acc_or_d  = 1'b0;
                        count_d   = '0;
`ifdef REDUCE_XOR_EN
                        acc_xor_d = 1'b0;
`endif
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    // State and accumulator registers, asynchronously forced to an empty frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_and_q <= 1'b1;
            acc_or_q  <= 1'b0;
            count_q   <= '0;
`ifdef REDUCE_XOR_EN
            acc_xor_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_and_q <= acc_and_d;
            acc_or_q  <= acc_or_d;
            count_q   <= count_d;
`ifdef REDUCE_XOR_EN
            acc_xor_q <= acc_xor_d;
`endif
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign x         = acc_and_q;
    assign y         = acc_or_q;
    assign count     = count_q;
`ifdef REDUCE_XOR_EN
    assign z         = acc_xor_q;
`endif

endmodule
